// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: reset/stall levels, bus widths
// and the fetch state encoding.
package if_fetch_pkg;

  localparam logic RstEnable = 1'b0;
  localparam logic Stop      = 1'b1;
  localparam logic NoStop    = 1'b0;

  localparam int InstAddrBus = 32;
  localparam int InstBus     = 32;

  localparam logic [InstAddrBus-1:0] ZeroWord = 32'h0000_0000;

  typedef enum logic [2:0] {
    IF_IDLE    = 3'd0,
    IF_WAIT    = 3'd1,
    IF_VALID   = 3'd2,
    IF_DISCARD = 3'd3,
    IF_EXCP    = 3'd4
  } if_state_e;

endpackage

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, runs the I-memory req/ack handshake, applies
// branch redirects. Define IF_ALIGN_CHK_EN to trap misaligned branch targets.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [InstAddrBus-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [InstAddrBus-1:0] PC_STEP  = 32'd4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [5:0]             stall,
  input  logic                   branch_flag_i,
  input  logic [InstAddrBus-1:0] branch_target_address_i,
  output logic                   inst_req,
  output logic [InstAddrBus-1:0] inst_addr,
  input  logic                   inst_ack,
  input  logic [InstBus-1:0]     inst_rdata,
  output logic [InstAddrBus-1:0] if_pc,
  output logic [InstBus-1:0]     if_inst,
`ifdef IF_ALIGN_CHK_EN
  output logic                   if_excp_adel,
`endif
  output logic                   stallreq_from_if
);

  if_state_e              state, state_nxt;
  logic [InstAddrBus-1:0] pc, pc_nxt, req_addr, target;
  logic                   branch_taken, capture;

  assign branch_taken = branch_flag_i && (stall[0] == NoStop);

`ifdef IF_ALIGN_CHK_EN
  logic misaligned, unused_stall;
  assign target       = branch_target_address_i;
  assign misaligned   = |branch_target_address_i[1:0];
  assign unused_stall = ^stall[5:1];
`else
  logic unused_bits;
  assign target      = {branch_target_address_i[InstAddrBus-1:2], 2'b00};
  assign unused_bits = ^{stall[5:1], branch_target_address_i[1:0]};
`endif

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    capture   = 1'b0;
    case (state)
      IF_IDLE: state_nxt = IF_WAIT;
      IF_WAIT: begin
        if (branch_taken) begin
          // With an ack the stale word is simply dropped and the new request starts next cycle.
          pc_nxt    = target;
          state_nxt = inst_ack ? IF_WAIT : IF_DISCARD;
        end else if (inst_ack) begin
          capture   = 1'b1;
          pc_nxt    = pc + PC_STEP;
          state_nxt = IF_VALID;
        end
      end
      IF_VALID: begin
        if (branch_taken) begin
          pc_nxt    = target;
          state_nxt = IF_WAIT;
        end else if (stall[0] != Stop) begin
          state_nxt = IF_WAIT;
        end
      end
      IF_DISCARD: begin
        if (branch_taken) pc_nxt = target;
        if (inst_ack) state_nxt = IF_WAIT;
      end
`ifdef IF_ALIGN_CHK_EN
      IF_EXCP: begin
        if (branch_taken) begin
          pc_nxt    = target;
          state_nxt = IF_WAIT;
        end
      end
`endif
      default: state_nxt = IF_IDLE;
    endcase
`ifdef IF_ALIGN_CHK_EN
    if (branch_taken && misaligned && (state != IF_IDLE)) begin
      pc_nxt    = target;
      state_nxt = IF_EXCP;
      capture   = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state    <= IF_IDLE;
      pc       <= RESET_PC;
      req_addr <= ZeroWord;
      if_pc    <= ZeroWord;
      if_inst  <= ZeroWord;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      // Remember the address on the bus so a redirect cannot disturb an outstanding request.
      if (state == IF_WAIT) req_addr <= pc;
      if (capture) begin
        if_pc   <= pc;
        if_inst <= inst_rdata;
      end
`ifdef IF_ALIGN_CHK_EN
      if (state_nxt == IF_EXCP) begin
        if_pc   <= pc_nxt;
        if_inst <= ZeroWord;
      end
`endif
    end
  end

  always_comb begin
    inst_req  = 1'b0;
    inst_addr = ZeroWord;
    case (state)
      IF_WAIT: begin
        inst_req  = 1'b1;
        inst_addr = pc;
      end
      IF_DISCARD: begin
        inst_req  = 1'b1;
        inst_addr = req_addr;
      end
      default: ;
    endcase
  end

  assign stallreq_from_if = inst_req;

`ifdef IF_ALIGN_CHK_EN
  assign if_excp_adel = (state == IF_EXCP);
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Randomised bench for if_fetch against a flag-based behavioural fetch model, with a
// memory responder of variable latency; directed phases cover the boundary cases.
module tb_if_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        branch_flag_i;
  logic [31:0] branch_target_address_i;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_ack;
  logic [31:0] inst_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        stallreq_from_if;
`ifdef IF_ALIGN_CHK_EN
  logic        if_excp_adel;
`endif

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          lat = 0;
  int          age = 0;
  bit          lat_rand = 1'b0;
  logic        force_ack = 1'b0;
  logic [31:0] salt = 32'h0;

  // Memory responder: acks once the request has been up for 'lat' cycles.
  assign inst_ack   = force_ack | (inst_req & (age >= lat));
  assign inst_rdata = {inst_addr[15:0], inst_addr[31:16]} ^ salt;

  if_fetch #(.RESET_PC(RST_PC), .PC_STEP(32'd4)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .stall                   (stall),
    .branch_flag_i           (branch_flag_i),
    .branch_target_address_i (branch_target_address_i),
    .inst_req                (inst_req),
    .inst_addr               (inst_addr),
    .inst_ack                (inst_ack),
    .inst_rdata              (inst_rdata),
    .if_pc                   (if_pc),
    .if_inst                 (if_inst),
`ifdef IF_ALIGN_CHK_EN
    .if_excp_adel            (if_excp_adel),
`endif
    .stallreq_from_if        (stallreq_from_if)
  );

  // Reference model: what the fetch unit is doing, as flags rather than states.
  bit          m_boot, m_pend, m_drop, m_held, m_exc;
  logic [31:0] m_pc, m_addr, m_ifpc, m_ifinst;

  bit          mcheck = 1'b0;
  int          cyc_n = 0;
  int          stall_cnt = 0;
  int          addr_bad = 0;
  bit          watch_en = 1'b0;
  logic [31:0] watch_addr = 32'h0;
  bit          watch_stale = 1'b0;
  bit          saw_stale = 1'b0;
  logic [31:0] ack_q[$];
  int          ackc_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc_n);
    end
  endtask

  task automatic model_step(input logic c_rst, input logic c_s0, input logic c_br,
                            input logic [31:0] c_tgt, input logic c_ack,
                            input logic [31:0] c_rd);
    bit          taken, mis;
    logic [31:0] tgt;
    taken = c_br && !c_s0;
`ifdef IF_ALIGN_CHK_EN
    tgt = c_tgt;
    mis = (c_tgt[1:0] != 2'b00);
`else
    tgt = c_tgt & 32'hFFFF_FFFC;
    mis = 1'b0;
`endif
    if (!c_rst) begin
      m_boot = 1'b1; m_pend = 1'b0; m_drop = 1'b0; m_held = 1'b0; m_exc = 1'b0;
      m_pc = RST_PC; m_addr = 32'h0; m_ifpc = 32'h0; m_ifinst = 32'h0;
    end else if (m_boot) begin
      m_boot = 1'b0; m_pend = 1'b1; m_drop = 1'b0; m_addr = m_pc;
    end else if (taken && mis) begin
      m_pend = 1'b0; m_drop = 1'b0; m_held = 1'b0; m_exc = 1'b1;
      m_pc = tgt; m_ifpc = tgt; m_ifinst = 32'h0;
    end else if (m_exc) begin
      if (taken) begin
        m_exc = 1'b0; m_pc = tgt; m_pend = 1'b1; m_addr = tgt;
      end
    end else if (m_pend) begin
      if (c_ack) begin
        if (!m_drop && !taken) begin
          m_ifpc = m_addr; m_ifinst = c_rd; m_pc = m_addr + 32'd4;
          m_pend = 1'b0; m_held = 1'b1;
        end else begin
          if (taken) m_pc = tgt;
          m_drop = 1'b0; m_addr = m_pc;
        end
      end else if (taken) begin
        m_pc = tgt; m_drop = 1'b1;
      end
    end else if (m_held) begin
      if (taken) m_pc = tgt;
      if (taken || !c_s0) begin
        m_held = 1'b0; m_pend = 1'b1; m_addr = m_pc;
      end
    end
  endtask

  // One clock: inputs are already set (at the negedge); check, then advance.
  task automatic cyc();
    logic        c_rst, c_s0, c_br, c_ack, c_req, c_sr;
    logic [31:0] c_tgt, c_rd, c_addr, c_ifpc;
    #1;
    c_rst = rst; c_s0 = stall[0]; c_br = branch_flag_i; c_tgt = branch_target_address_i;
    c_ack = inst_ack; c_rd = inst_rdata; c_req = inst_req; c_sr = stallreq_from_if;
    c_addr = inst_addr; c_ifpc = if_pc;
    if (mcheck) begin
      check_val("req", 32'(inst_req), 32'(m_pend));
      check_val("addr", inst_addr, m_pend ? m_addr : 32'h0);
      check_val("stallreq", 32'(stallreq_from_if), 32'(m_pend));
      check_val("if_pc", if_pc, m_ifpc);
      check_val("if_inst", if_inst, m_ifinst);
`ifdef IF_ALIGN_CHK_EN
      check_val("adel", 32'(if_excp_adel), 32'(m_exc));
`endif
    end
    if (c_sr) stall_cnt++;
    if (watch_en && c_req && (c_addr != watch_addr)) addr_bad++;
    if (watch_stale && ((c_ifpc == 32'h18) || (c_ifpc == 32'h1C))) saw_stale = 1'b1;
    if (c_rst && c_req && c_ack) begin
      ack_q.push_back(c_addr);
      ackc_q.push_back(cyc_n);
    end
    @(posedge clk);
    @(negedge clk);
    model_step(c_rst, c_s0, c_br, c_tgt, c_ack, c_rd);
    if (!c_rst || !c_req || c_ack) begin
      age = 0;
      if (lat_rand) lat = $urandom_range(0, 3);
    end else begin
      age++;
    end
    salt = $urandom;
    cyc_n++;
  endtask

  task automatic wait_acks(input int k);
    int n = 0;
    while ((ack_q.size() < k) && (n < 50)) begin
      cyc();
      n++;
    end
    check_val("ack_wait", 32'(ack_q.size() >= k), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    int          r;
    logic [31:0] tgt;
    rst = 1'b0; stall = 6'h0; branch_flag_i = 1'b0; branch_target_address_i = 32'h0;
    @(negedge clk);
    cyc();
    mcheck = 1'b1;
    repeat (2) cyc();
    check_val("rst_req", 32'(inst_req), 32'd0);
    check_val("rst_ifpc", if_pc, 32'h0);
    check_val("rst_stallreq", 32'(stallreq_from_if), 32'd0);

    // Zero-wait fetch after reset release
    rst = 1'b1;
    n = 0;
    while (!inst_req && (n < 5)) begin
      cyc();
      n++;
    end
    check_val("req_rise_cycles", 32'(n), 32'd1);
    check_val("first_addr", inst_addr, 32'h0);
    wait_acks(2);
    check_val("seq_addr0", ack_q[0], 32'h0);
    check_val("seq_addr4", ack_q[1], 32'h4);
    check_val("seq_spacing", 32'(ackc_q[1] - ackc_q[0]), 32'd2);

    // Slow memory on the fetch of 0x8
    lat = 2; stall_cnt = 0; watch_en = 1'b1; watch_addr = 32'h8; addr_bad = 0;
    wait_acks(3);
    watch_en = 1'b0;
    check_val("slow_stall_cycles", 32'(stall_cnt), 32'd3);
    check_val("slow_addr_hold", 32'(addr_bad), 32'd0);
    check_val("slow_addr", ack_q[2], 32'h8);

    // Stall while holding 0x10
    lat = 0;
    wait_acks(5);
    check_val("hold_pc_before", if_pc, 32'h10);
    stall = 6'h01; stall_cnt = 0;
    repeat (4) cyc();
    check_val("stall_noreq", 32'(stall_cnt), 32'd0);
    check_val("stall_hold_pc", if_pc, 32'h10);
    stall = 6'h00;
    wait_acks(6);
    check_val("after_stall_addr", ack_q[5], 32'h14);

    // Branch while a slow fetch is outstanding
    lat = 2; watch_stale = 1'b1;
    cyc();
    branch_flag_i = 1'b1; branch_target_address_i = 32'h100;
    cyc();
    branch_flag_i = 1'b0;
    check_val("discard_addr", inst_addr, 32'h18);
    check_val("discard_stallreq", 32'(stallreq_from_if), 32'd1);
    n = 0;
    while (!(inst_req && (inst_addr == 32'h100)) && (n < 10)) begin
      cyc();
      n++;
    end
    check_val("redirect_addr", inst_addr, 32'h100);
    n = 0;
    while ((if_pc != 32'h100) && (n < 10)) begin
      cyc();
      n++;
    end
    check_val("redirect_ifpc", if_pc, 32'h100);
    check_val("no_stale_pc", 32'(saw_stale), 32'd0);
    watch_stale = 1'b0;

    // Branch in the same cycle as a zero-wait ack
    lat = 0;
    cyc();
    branch_flag_i = 1'b1; branch_target_address_i = 32'h200;
    cyc();
    branch_flag_i = 1'b0;
    check_val("br_ack_req", 32'(inst_req), 32'd1);
    check_val("br_ack_addr", inst_addr, 32'h200);
    check_val("br_ack_ifpc", if_pc, 32'h100);

    // Reset during DISCARD, then a late ack
    lat = 3;
    branch_flag_i = 1'b1; branch_target_address_i = 32'h300;
    cyc();
    branch_flag_i = 1'b0;
    check_val("pre_rst_discard", inst_addr, 32'h200);
    rst = 1'b0;
    cyc();
    rst = 1'b1; force_ack = 1'b1;
    cyc();
    force_ack = 1'b0;
    check_val("restart_req", 32'(inst_req), 32'd1);
    check_val("restart_addr", inst_addr, RST_PC);
    check_val("restart_ifpc", if_pc, 32'h0);

    // PC wrap at the top of the address space
    lat = 0;
    n = 0;
    while (inst_req && (n < 10)) begin
      cyc();
      n++;
    end
    branch_flag_i = 1'b1; branch_target_address_i = 32'hFFFF_FFFC;
    cyc();
    branch_flag_i = 1'b0;
    check_val("wrap_req_addr", inst_addr, 32'hFFFF_FFFC);
    cyc();
    check_val("wrap_ifpc", if_pc, 32'hFFFF_FFFC);
    cyc();
    check_val("wrap_next_addr", inst_addr, 32'h0);

    // Misaligned branch target
    cyc();
    branch_flag_i = 1'b1; branch_target_address_i = 32'h102;
    cyc();
    branch_flag_i = 1'b0;
`ifdef IF_ALIGN_CHK_EN
    check_val("adel_flag", 32'(if_excp_adel), 32'd1);
    check_val("adel_ifpc", if_pc, 32'h102);
    check_val("adel_noreq", 32'(inst_req), 32'd0);
    stall_cnt = 0;
    repeat (3) cyc();
    check_val("adel_hold_noreq", 32'(stall_cnt), 32'd0);
    branch_flag_i = 1'b1; branch_target_address_i = 32'h400;
    cyc();
    branch_flag_i = 1'b0;
    check_val("adel_exit_addr", inst_addr, 32'h400);
    check_val("adel_exit_flag", 32'(if_excp_adel), 32'd0);
`else
    check_val("align_req", 32'(inst_req), 32'd1);
    check_val("align_addr", inst_addr, 32'h100);
`endif

    // Randomised traffic
    lat_rand = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 99) != 0);
      stall = 6'($urandom);
      stall[0] = ($urandom_range(0, 3) == 0);
      branch_flag_i = ($urandom_range(0, 6) == 0);
      r = $urandom_range(0, 9);
      if (r == 0)      tgt = 32'hFFFF_FFFC;
      else if (r == 1) tgt = $urandom;
      else             tgt = $urandom & 32'h0000_0FFC;
      branch_target_address_i = tgt;
      force_ack = ($urandom_range(0, 19) == 0);
      cyc();
    end
    rst = 1'b1; branch_flag_i = 1'b0; force_ack = 1'b0; stall = 6'h0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
